profile_counter_streamer: RTL

- Downstream consumer of the cache profiler's six 32-bit event counters (icache hit/miss/request, dcache hit/miss/request).
- On a snapshot request it atomically captures all counters into shadow registers.
- It then serialises them as a framed byte stream over a valid/ready interface to the host-link transmitter (UART/debug TX).
- Frame: header byte, counters MSB-first, XOR checksum byte.

---
 rtl/profile_counter_streamer_if.sv | 11 +
 rtl/profile_counter_streamer.sv | 102 ++++++++++
 2 files changed

// File: rtl/profile_counter_streamer_if.sv
// Byte stream from the counter streamer to the host-link transmitter.
// The master presents bytes; the slave accepts one on each cycle where valid && ready.
interface profile_counter_streamer_if;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;

   modport master (output out_valid, output out_data, output out_last, input out_ready);
   modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/profile_counter_streamer.sv
// Snapshots the cache-profiler counters and streams them as one frame:
// a header byte, the counters MSB-first, then an XOR checksum byte.
module profile_counter_streamer #(
   parameter int             NUM_COUNTERS = 6,
   parameter logic [7:0]     HEADER_BYTE  = 8'hA5,
   parameter int             DROP_W       = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic                         snapshot_req,
   input  logic [NUM_COUNTERS*32-1:0]   counters,
   profile_counter_streamer_if.master   stream,
   output logic                         busy,
   output logic [DROP_W-1:0]            dropped_snapshots
);
   localparam int CW = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(NUM_COUNTERS - 1);

   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, CHECKSUM} state_t;

   state_t                         state;
   logic [NUM_COUNTERS-1:0][31:0]  shadow;
   logic [CW-1:0]                  cnt_idx, nxt_cnt;
   logic [1:0]                     byte_idx, nxt_byte;
   logic [7:0]                     csum, nxt_val;
   logic [31:0]                    word;
   logic                           fire;

   assign fire = stream.out_valid && stream.out_ready;

   // Byte that follows the one currently presented in PAYLOAD.
   always_comb begin
      nxt_byte = byte_idx + 2'd1;
      nxt_cnt  = cnt_idx;
      if (byte_idx == 2'd3) nxt_cnt = cnt_idx + 1'b1;
      word = shadow[nxt_cnt];
      case (nxt_byte)
         2'd0:    nxt_val = word[31:24];
         2'd1:    nxt_val = word[23:16];
         2'd2:    nxt_val = word[15:8];
         default: nxt_val = word[7:0];
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= IDLE;
         shadow            <= '0;
         cnt_idx           <= '0;
         byte_idx          <= '0;
         csum              <= '0;
         busy              <= 1'b0;
         dropped_snapshots <= '0;
         stream.out_valid  <= 1'b0;
         stream.out_data   <= '0;
         stream.out_last   <= 1'b0;
      end else begin
         // Requests arriving any time a frame is in flight, final handshake included, are dropped.
         if (snapshot_req && state != IDLE && dropped_snapshots != '1)
            dropped_snapshots <= dropped_snapshots + 1'b1;

         case (state)
            IDLE: if (snapshot_req && enable) begin
               shadow           <= counters;
               csum             <= '0;
               cnt_idx          <= '0;
               byte_idx         <= '0;
               busy             <= 1'b1;
               stream.out_valid <= 1'b1;
               stream.out_data  <= HEADER_BYTE;
               stream.out_last  <= 1'b0;
               state            <= HEADER;
            end
            HEADER: if (fire) begin
               stream.out_data <= shadow[0][31:24];
               state           <= PAYLOAD;
            end
            PAYLOAD: if (fire) begin
               csum <= csum ^ stream.out_data;
               if (cnt_idx == LAST_CNT && byte_idx == 2'd3) begin
                  stream.out_data <= csum ^ stream.out_data;
                  stream.out_last <= 1'b1;
                  state           <= CHECKSUM;
               end else begin
                  cnt_idx         <= nxt_cnt;
                  byte_idx        <= nxt_byte;
                  stream.out_data <= nxt_val;
               end
            end
            CHECKSUM: if (fire) begin
               stream.out_valid <= 1'b0;
               stream.out_last  <= 1'b0;
               stream.out_data  <= '0;
               busy             <= 1'b0;
               state            <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
